// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared constants for the fetch next-IP sequencer: FSM encodings and address defaults.
package fetch_seq_ctrl_pkg;

  localparam int              AW        = 16;
  localparam logic [AW-1:0]   RESET_VEC = 16'h0000;

  localparam logic [0:0]      ST_RUN    = 1'b0;
  localparam logic [0:0]      ST_HALTED = 1'b1;

endpackage

// File: rtl/fetch_seq_ctrl_ret_addr_stack.sv
// Hardware return-address stack: DEPTH x AW entries with a registered depth pointer.
module ret_addr_stack #(
  parameter int AW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_addr,
  output logic [AW-1:0]            top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] depth_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign wr_idx  = depth_q[IW-1:0];
  assign top_idx = wr_idx - IW'(1);
  assign full    = (depth_q == PW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign top     = mem[top_idx];
  assign depth   = depth_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + PW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - PW'(1);
    end
  end

  // Entry storage carries no reset; only the pointer decides validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_addr;
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Next-IP sequencer: sequential advance, stall, branch, CALL/RET via RAS, HALT/RESUME.
module fetch_seq_ctrl #(
  parameter int                AW        = fetch_seq_ctrl_pkg::AW,
  parameter int                RAS_DEPTH = 8,
  parameter logic [AW-1:0]     RESET_VEC = fetch_seq_ctrl_pkg::RESET_VEC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AW-1:0]                ip,
  input  logic                         stall,
  input  logic                         br_taken,
  input  logic [AW-1:0]                br_pc,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         halt,
  input  logic                         resume,
  output logic [AW-1:0]                next_ip,
  output logic                         flush,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_depth,
  output logic                         ras_err
);

  import fetch_seq_ctrl_pkg::*;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic          flush_d;
  logic          err_set;
  logic          ras_push;
  logic          ras_pop;
  logic [AW-1:0] ras_top;
  logic          ras_full;
  logic          ras_empty;

  // Sequential successor, modulo 2^AW with silent wrap.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return a + AW'(1);
  endfunction

  ret_addr_stack #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (addr_inc(ip)),
    .top       (ras_top),
    .depth     (ras_depth),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    next_ip  = addr_inc(ip);
    state_d  = state_q;
    flush_d  = 1'b0;
    err_set  = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (rst) begin
      next_ip = RESET_VEC;
    end else if (state_q == ST_HALTED) begin
      next_ip = ip;
      if (resume && !halt) state_d = ST_RUN;
    end else if (halt) begin
      next_ip = ip;
      state_d = ST_HALTED;
    end else if (stall) begin
      next_ip = ip;
    end else if (ret) begin
      if (!ras_empty) begin
        next_ip = ras_top;
        ras_pop = 1'b1;
        flush_d = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (call) begin
      next_ip = br_pc;
      flush_d = 1'b1;
      if (ras_full) err_set  = 1'b1;
      else          ras_push = 1'b1;
    end else if (br_taken) begin
      next_ip = br_pc;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      flush   <= 1'b0;
      ras_err <= 1'b0;
    end else begin
      state_q <= state_d;
      flush   <= flush_d;
      if (err_set) ras_err <= 1'b1;
    end
  end

  assign halted = (state_q == ST_HALTED);

endmodule
